// File: rtl/ahb_lite_reg_bridge.sv
// AHB-Lite slave front end: turns pipelined address/data phases into a one-cycle
// register access strobe, with optional wait states and a two-cycle ERROR response.
module ahb_lite_reg_bridge #(
  parameter int ADDRWIDTH   = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 hsels,
  input  logic [ADDRWIDTH-1:0] haddrs,
  input  logic [1:0]           htranss,
  input  logic [2:0]           hsizes,
  input  logic                 hwrites,
  input  logic                 hreadys,
  input  logic [31:0]          hwdatas,
  output logic                 hreadyouts,
  output logic                 hresps,
  output logic [31:0]          hrdatas,
  output logic [ADDRWIDTH-1:0] addr,
  output logic                 read_en,
  output logic                 write_en,
  output logic [3:0]           byte_strobe,
  output logic [31:0]          wdata,
  input  logic [31:0]          rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Counter preload; the WAIT state leaves as soon as the counter reads zero,
  // so WAIT_STATES-1 here yields exactly WAIT_STATES low-HREADYOUT cycles.
  localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  state_e                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [3:0]             strobe_q, strobe_d;
  logic                   hreadyout_q;
  logic                   hresp_q;
  logic                   read_en_q;
  logic                   write_en_q;
  logic [3:0]             byte_strobe_q;

  logic                   trans_req;
  logic                   can_accept;
  logic                   accept;
  logic                   size_err;
  logic                   align_err;
  logic                   xfer_err;
  logic [3:0]             strobe_gen;

  // Address-phase decode
  assign trans_req  = hsels & hreadys & htranss[1];
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_ACCESS) || (state_q == ST_ERR2);
  assign accept     = trans_req & can_accept;

  assign size_err  = (hsizes > 3'd2);
  assign align_err = ((hsizes == 3'd1) && haddrs[0]) ||
                     ((hsizes == 3'd2) && (haddrs[1:0] != 2'b00));
  assign xfer_err  = size_err | align_err;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    strobe_gen = 4'b0000;
    unique case (hsizes)
      3'd0:    strobe_gen = 4'b0001 << haddrs[1:0];
      3'd1:    strobe_gen = haddrs[1] ? 4'b1100 : 4'b0011;
      3'd2:    strobe_gen = 4'b1111;
      default: strobe_gen = 4'b0000;
    endcase
  end

  // Transfer attributes are captured only when a transfer is accepted
  assign addr_d   = accept ? {haddrs[ADDRWIDTH-1:2], 2'b00} : addr_q;
  assign write_d  = accept ? hwrites : write_q;
  assign strobe_d = accept ? strobe_gen : strobe_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_ACCESS, ST_ERR2: begin
        if (accept) begin
          if (xfer_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: hresetn is asynchronous and active-low; sequential state uses
  // non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 2'd0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      strobe_q      <= 4'b0000;
      hreadyout_q   <= 1'b1;
      hresp_q       <= 1'b0;
      read_en_q     <= 1'b0;
      write_en_q    <= 1'b0;
      byte_strobe_q <= 4'b0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      strobe_q      <= strobe_d;
      // Outputs are decoded from the next state so they line up with it
      hreadyout_q   <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
      hresp_q       <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
      read_en_q     <= (state_d == ST_ACCESS) && !write_d;
      write_en_q    <= (state_d == ST_ACCESS) && write_d;
      byte_strobe_q <= (state_d == ST_ACCESS) ? strobe_d : 4'b0000;
    end
  end

  assign hreadyouts  = hreadyout_q;
  assign hresps      = hresp_q;
  assign addr        = addr_q;
  assign read_en     = read_en_q;
  assign write_en    = write_en_q;
  assign byte_strobe = byte_strobe_q;
  assign wdata       = hwdatas;
  // Register file read data is only forwarded during a read access cycle
  assign hrdatas     = read_en_q ? rdata : 32'h0000_0000;

endmodule
